div4_restoring: RTL and testbench

DIV4_RESTORING -- requirements
Module: div4_restoring

---
 rtl/div_pkg.sv | 10 +
 rtl/sub_ripple.sv | 21 ++
 rtl/div4_restoring.sv | 102 ++++++++++
 tb/tb_div4_restoring.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider.
package div_pkg;
   localparam int DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;
endpackage

// File: rtl/sub_ripple.sv
// Combinational ripple-borrow subtractor: Diff = A - B - Bin, Bout = final borrow.
module sub_ripple #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);
   logic [WIDTH:0] bw;

   assign bw[0] = Bin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fs
      assign Diff[i]  = A[i] ^ B[i] ^ bw[i];
      assign bw[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw[i]);
   end

   assign Bout = bw[WIDTH];
endmodule

// File: rtl/div4_restoring.sv
// Multi-cycle restoring unsigned divider: one quotient bit per RUN cycle,
// registered results and a one-cycle Done pulse.
module div4_restoring
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [WIDTH:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvs;

   logic [WIDTH:0]   p;
   logic [WIDTH:0]   diff;
   logic             bout;
   logic [WIDTH:0]   r_nxt;
   logic [WIDTH-1:0] q_nxt;

   // Shift the next dividend bit into the partial remainder
   assign p = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};

   sub_ripple #(.WIDTH(WIDTH + 1)) u_sub (
      .A    (p),
      .B    ({1'b0, dvs}),
      .Bin  (1'b0),
      .Diff (diff),
      .Bout (bout)
   );

   assign r_nxt = bout ? p : diff;
   assign q_nxt = {q[WIDTH-2:0], ~bout};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         cnt       <= '0;
         r         <= '0;
         q         <= '0;
         dvs       <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  q   <= Dividend;
                  dvs <= Divisor;
                  r   <= '0;
                  cnt <= CW'(WIDTH - 1);
                  if (Divisor == '0) begin
                     state     <= DONE;
                     Quotient  <= '1;
                     Remainder <= Dividend;
                     DivByZero <= 1'b1;
                  end else begin
                     state <= RUN;
                     Busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               q   <= q_nxt;
               r   <= r_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  state     <= DONE;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  Quotient  <= q_nxt;
                  Remainder <= r_nxt[WIDTH-1:0];
                  DivByZero <= 1'b0;
               end
            end
            // Normal entry arrives with Done already set; divide-by-zero enters
            // with Done low and spends one extra cycle here to raise it.
            DONE: begin
               if (Done) state <= IDLE;
               else      Done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div4_restoring.sv
// Scoreboard bench for div4_restoring: expectations queued at launch, popped at Done.
module tb_div4_restoring;
   localparam int W = 4;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic [W-1:0] Dividend = '0;
   logic [W-1:0] Divisor = '0;
   logic         Busy, Done, DivByZero;
   logic [W-1:0] Quotient, Remainder;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   div4_restoring #(.WIDTH(W)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivByZero (DivByZero)
   );

   always #5 Clk = ~Clk;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic exp_t got();
      exp_t g;
      g.q = Quotient; g.r = Remainder; g.dz = DivByZero;
      return g;
   endfunction

   function automatic exp_t pop_exp();
      exp_t e;
      e = '0;
      if (sbq.size() > 0) e = sbq.pop_front();
      return e;
   endfunction

   // Capture on the next edge, then scramble the operand pins
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      @(negedge Clk);
      Dividend = a; Divisor = b; Start = 1'b1;
      sbq.push_back(model(a, b));
      @(posedge Clk);
      #1;
      if (!hold) Start = 1'b0;
      Dividend = W'($urandom);
      Divisor  = W'($urandom);
   endtask

   // lat = edges after the capture edge until Done is seen
   task automatic wait_done(output int lat, output int busy, output int both, output bit to);
      lat = 0; busy = 0; both = 0; to = 1'b0;
      forever begin
         @(negedge Clk);
         if (Busy) busy++;
         if (Busy && Done) both++;
         if (Done) break;
         if (lat >= 40) begin to = 1'b1; break; end
         @(posedge Clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({Busy, Done, DivByZero, Quotient, Remainder} !== '0) begin
         errors++;
         $display("FAIL reset_state got b=%b d=%b z=%b q=%0d r=%0d exp all 0",
                  Busy, Done, DivByZero, Quotient, Remainder);
      end
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_basic();
      int lat, busy, both; bit to; exp_t e;
      launch(4'd13, 4'd4, 1'b0);
      wait_done(lat, busy, both, to);
      e = pop_exp();
      checks++;
      if (to || lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4 (to=%0b)", lat, to); end
      checks++;
      if (busy !== 4 || both !== 0) begin errors++; $display("FAIL basic_busy got busy=%0d overlap=%0d exp 4/0", busy, both); end
      checks++;
      if (got() !== e || e !== {4'd3, 4'd1, 1'b0}) begin
         errors++; $display("FAIL basic_13_4 got q=%0d r=%0d z=%b exp q=3 r=1 z=0", Quotient, Remainder, DivByZero);
      end
      @(posedge Clk); @(negedge Clk);
      checks++;
      if (Done !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", Done); end
   endtask

   task automatic test_patterns();
      logic [W-1:0] ta[3] = '{4'd15, 4'd7, 4'd15};
      logic [W-1:0] tb[3] = '{4'd1, 4'd9, 4'd15};
      logic [W-1:0] tq[3] = '{4'd15, 4'd0, 4'd1};
      logic [W-1:0] tr[3] = '{4'd0, 4'd7, 4'd0};
      int lat, busy, both; bit to; exp_t e;
      for (int i = 0; i < 3; i++) begin
         launch(ta[i], tb[i], 1'b0);
         wait_done(lat, busy, both, to);
         e = pop_exp();
         checks++;
         if (to || got() !== e || Quotient !== tq[i] || Remainder !== tr[i] || DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL pattern_%0d_%0d got q=%0d r=%0d z=%b exp q=%0d r=%0d z=0 (to=%0b)",
                     ta[i], tb[i], Quotient, Remainder, DivByZero, tq[i], tr[i], to);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, busy, both; bit to; exp_t e;
      launch(4'd9, 4'd0, 1'b0);
      wait_done(lat, busy, both, to);
      e = pop_exp();
      checks++;
      if (to || lat !== 1 || busy !== 0) begin
         errors++; $display("FAIL divzero_timing got lat=%0d busy=%0d exp lat=1 busy=0 (to=%0b)", lat, busy, to);
      end
      checks++;
      if (got() !== e || e !== {4'hF, 4'd9, 1'b1}) begin
         errors++; $display("FAIL divzero_result got q=%0d r=%0d z=%b exp q=15 r=9 z=1", Quotient, Remainder, DivByZero);
      end
      @(posedge Clk); @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL divzero_done_width got d=%b b=%b exp 0/0", Done, Busy); end
   endtask

   task automatic test_start_ignored();
      int ndone; exp_t e, cap;
      ndone = 0; cap = '0;
      launch(4'd12, 4'd5, 1'b0);
      @(negedge Clk);
      Dividend = 4'd1; Divisor = 4'd1; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(negedge Clk);
         if (Done) begin ndone++; cap = got(); end
         @(posedge Clk);
      end
      e = pop_exp();
      checks++;
      if (ndone !== 1) begin errors++; $display("FAIL ignored_done_count got %0d exp 1", ndone); end
      checks++;
      if (cap !== e || e !== {4'd2, 4'd2, 1'b0}) begin
         errors++; $display("FAIL ignored_result got q=%0d r=%0d exp q=2 r=2", cap.q, cap.r);
      end
   endtask

   task automatic test_reset_abort();
      int lat, busy, both, ndone; bit to; exp_t e;
      launch(4'd14, 4'd3, 1'b0);
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      checks++;
      if ({Busy, Done, DivByZero, Quotient, Remainder} !== '0) begin
         errors++;
         $display("FAIL abort_outputs got b=%b d=%b z=%b q=%0d r=%0d exp all 0",
                  Busy, Done, DivByZero, Quotient, Remainder);
      end
      void'(sbq.pop_back());
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge Clk);
         if (Done) ndone++;
         if (c == 2) Reset = 1'b0;
      end
      checks++;
      if (ndone !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
      launch(4'd14, 4'd3, 1'b0);
      wait_done(lat, busy, both, to);
      e = pop_exp();
      checks++;
      if (to || lat !== 4 || got() !== e || e !== {4'd4, 4'd2, 1'b0}) begin
         errors++; $display("FAIL after_abort got q=%0d r=%0d lat=%0d exp q=4 r=2 lat=4", Quotient, Remainder, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat, busy, both; bit to; exp_t e;
      launch(4'd6, 4'd2, 1'b1);
      wait_done(lat, busy, both, to);
      e = pop_exp();
      checks++;
      if (to || got() !== e) begin errors++; $display("FAIL b2b_first got q=%0d r=%0d exp q=%0d r=%0d", Quotient, Remainder, e.q, e.r); end
      Dividend = 4'd11; Divisor = 4'd3;
      sbq.push_back(model(4'd11, 4'd3));
      @(posedge Clk);
      @(posedge Clk);
      #1 Start = 1'b0;
      wait_done(lat, busy, both, to);
      e = pop_exp();
      checks++;
      if (to || lat !== 4 || got() !== e) begin
         errors++; $display("FAIL b2b_second got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=4", Quotient, Remainder, lat, e.q, e.r);
      end
   endtask

   task automatic test_exhaustive();
      int lat, busy, both, bad; bit to; exp_t e;
      bad = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            launch(W'(a), W'(b), 1'b0);
            wait_done(lat, busy, both, to);
            e = pop_exp();
            checks++;
            if (to || got() !== e || lat !== ((b == 0) ? 1 : 4) || both !== 0) begin
               errors++;
               if (bad < 10)
                  $display("FAIL sweep_%0d_%0d got q=%0d r=%0d z=%b lat=%0d exp q=%0d r=%0d z=%b",
                           a, b, Quotient, Remainder, DivByZero, lat, e.q, e.r, e.dz);
               bad++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_exhaustive();
      checks++;
      if (sbq.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sbq.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
